hex_str2word: RTL
=================

HEX_STR2WORD -- requirements
Module: hex_str2word

Interface
REQ-001 Parameter DIGITS, default 8: hex digits per word, range 1..16.
REQ-002 Parameter DOUT_W, default 4*DIGITS: output width, always equal to 4*DIGITS.
REQ-003 Parameter TIMEOUT, default 50000: maximum idle cycles between characters of one word; 0 disables the timeout.
REQ-004 Port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port din, input, 8 bits: ASCII character.
REQ-007 Port din_vld, input, 1 bit: din valid for this cycle; no backpressure.
REQ-008 Port dout, output, DOUT_W bits: assembled word, right-aligned, zero-extended.
REQ-009 Port dout_vld, output, 1 bit: one-cycle pulse when dout is updated.
REQ-010 Port err, output, 1 bit: one-cycle pulse on an aborted or invalid character.
REQ-011 Port busy, output, 1 bit: high while a word is partially collected.

Function
REQ-012 Hex class SHALL be:
- 0x30-0x39 -> 0-9
- 0x41-0x46 -> 10-15
- 0x61-0x66 -> 10-15
REQ-013 Delimiter class SHALL be 0x20, 0x0D, 0x0A and 0x2C; every other byte is invalid.
REQ-014 The block SHALL ignore din when din_vld is low.
REQ-015 The state machine SHALL have two states, IDLE and COLLECT; busy SHALL be high exactly in COLLECT.
REQ-016 IDLE behaviour:
- hex char -> acc = zero-extended digit, cnt = 1, go to COLLECT.
- delimiter -> ignored.
- invalid char -> err pulse, stay in IDLE.
REQ-017 COLLECT, hex char -> acc = {acc[DOUT_W-5:0], digit}, cnt = cnt + 1.
REQ-018 When cnt reaches DIGITS, the block SHALL do all of the following on the same edge: dout = new acc, dout_vld pulse, go to IDLE.
REQ-019 DIGITS=1 special case: a hex char in IDLE SHALL emit immediately (dout_vld pulse) and stay in IDLE.
REQ-020 COLLECT, delimiter -> dout = acc, dout_vld pulse, go to IDLE; the delimiter itself is consumed.
REQ-021 COLLECT, invalid char -> discard acc, err pulse, go to IDLE, no dout_vld.
REQ-022 Latency: dout_vld and err SHALL assert on the clock edge that samples the causing din_vld, i.e. visible the cycle after the input.
REQ-023 Timeout counter:
- counts consecutive COLLECT cycles with din_vld low;
- clears on every accepted character and on entry to IDLE.
REQ-024 When the timeout counter reaches TIMEOUT, the block SHALL discard acc, pulse err and go to IDLE.
- A din_vld in that same cycle takes priority over the timeout.
REQ-025 dout SHALL hold its last emitted value until the next emission; dout_vld and err SHALL never assert in the same cycle.
REQ-026 Back-to-back din_vld on every cycle SHALL be accepted without loss; a word completed on digit count SHALL allow the next hex char on the following cycle to start a new word.

Reset
REQ-027 While rst_n is low, the block SHALL force all of the following:
- dout = 0, dout_vld = 0, err = 0, busy = 0;
- state = IDLE;
- acc, cnt and timeout counter = 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word with no dout_vld or err.
REQ-029 After rst_n deasserts, the first din_vld SHALL be processed normally.

Verification
REQ-030 The bench SHALL cover these directed scenarios (all with DIGITS=4, TIMEOUT=16):
- "1A2f" -> dout=16'h1A2F, one dout_vld pulse the cycle after 'f', busy low afterwards.
- "3F\r" -> dout=16'h003F on CR; a following "\n" produces no output.
- "12G" -> err pulse after 'G', no dout_vld, dout keeps its previous value, busy low.
- "12", then 16 idle cycles -> err pulse; then "ABCD" on consecutive cycles -> dout=16'hABCD.
- "12", then rst_n pulse, then "34\n" -> dout=16'h0034, err never asserted.
- "FFFF0001" on eight consecutive cycles -> two dout_vld pulses, 16'hFFFF then 16'h0001, four cycles apart.

Source files
------------

// File: rtl/hex_str2word.sv
// ASCII hex string to word assembler: collects up to DIGITS hex characters,
// emits on digit count or delimiter, aborts on invalid characters or idle timeout.
module hex_str2word #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned DOUT_W  = 4 * DIGITS,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        din,
  input  logic              din_vld,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_vld,
  output logic              err,
  output logic              busy
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned TO_W  = 32;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t              state_q, state_d;
  logic [DOUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [DOUT_W-1:0]   dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;
  logic                err_q, err_d;

  logic                is_hex;
  logic                is_delim;
  logic [3:0]          digit;
  logic [DOUT_W-1:0]   acc_sh;
  logic [CNT_W-1:0]    cnt_inc;
  logic [TO_W-1:0]     to_inc;

  always_comb begin
    is_hex = 1'b0;
    digit  = 4'd0;
    if (din >= 8'h30 && din <= 8'h39) begin
      is_hex = 1'b1;
      digit  = din[3:0];
    end else if ((din >= 8'h41 && din <= 8'h46) || (din >= 8'h61 && din <= 8'h66)) begin
      is_hex = 1'b1;
      digit  = din[3:0] + 4'd9;
    end
    is_delim = (din == 8'h20) || (din == 8'h0D) || (din == 8'h0A) || (din == 8'h2C);
  end

  // Shift written as a truncating multiply-free shift so DIGITS=1 stays legal.
  assign acc_sh  = DOUT_W'(acc_q << 4) | DOUT_W'(digit);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign to_inc  = to_q + TO_W'(1);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        to_d = '0;
        if (din_vld) begin
          if (is_hex) begin
            if (DIGITS == 1) begin
              dout_d     = DOUT_W'(digit);
              dout_vld_d = 1'b1;
              acc_d      = '0;
              cnt_d      = '0;
            end else begin
              acc_d   = DOUT_W'(digit);
              cnt_d   = CNT_W'(1);
              state_d = COLLECT;
            end
          end else if (!is_delim) begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (din_vld) begin
          to_d = '0;
          if (is_hex) begin
            acc_d = acc_sh;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DIGITS)) begin
              dout_d     = acc_sh;
              dout_vld_d = 1'b1;
              state_d    = IDLE;
              acc_d      = '0;
              cnt_d      = '0;
            end
          end else if (is_delim) begin
            dout_d     = acc_q;
            dout_vld_d = 1'b1;
            state_d    = IDLE;
            acc_d      = '0;
            cnt_d      = '0;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          to_d = to_inc;
          if (TIMEOUT != 0 && to_inc == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            to_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        to_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_q      <= err_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign err      = err_q;
  assign busy     = (state_q == COLLECT);

endmodule
